imem_port_sequencer: RTL and testbench
======================================

Name: imem_port_sequencer

Overview:
- Sequences the single cell-wide port of the instruction memory and shares it between two requesters: the fetch stage (word reads) and the program loader (word writes).
- Each word is WORD_LEN/CELL_W cells, stored most-significant cell at the lowest address. The block splits every word transaction into one cell access per cycle.
- Sits between the IF stage / boot loader and the instruction memory array.

Parameters:
- CELL_W, 4, width of one memory cell in bits.
- CELLS, 4, cells per word; WORD_LEN = CELL_W*CELLS = 16.
- MEM_SIZE, 32, number of cells in instruction memory (power of 2).
- ADDR_W, $clog2(MEM_SIZE), cell address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- f_valid  in  1  fetch read request.
- f_addr  in  ADDR_W  fetch base cell address.
- f_ready  out  1  fetch request accepted this cycle.
- f_flush  in  1  cancel in-flight fetch read.
- f_rvalid  out  1  one-cycle pulse: f_rdata valid.
- f_rdata  out  WORD_LEN  assembled instruction word.
- l_valid  in  1  loader write request.
- l_addr  in  ADDR_W  loader base cell address.
- l_wdata  in  WORD_LEN  word to write.
- l_ready  out  1  loader request accepted this cycle.
- l_done  out  1  one-cycle pulse: last cell written.
- mem_addr  out  ADDR_W  cell address to memory.
- mem_we  out  1  cell write enable.
- mem_wdata  out  CELL_W  cell write data.
- mem_rdata  in  CELL_W  cell read data (combinational from mem_addr).

Behaviour:
- Reset (rst=0, async): state IDLE, beat=0, last_grant=FETCH. f_ready, l_ready, f_rvalid, l_done, mem_we, f_rdata, mem_addr, and mem_wdata are all 0.
- States: IDLE, READ, WRITE. beat counter runs 0..CELLS-1.
- IDLE arbitration (combinational readies):
  - Only one valid: its ready=1.
  - Both valid: grant the requester not in last_grant (round-robin), so the loader wins the first tie after reset.
  - Never both readies at once.
- Accept = valid & ready at a rising edge. On accept: latch base address (and l_wdata), set last_grant, beat=0, go to READ or WRITE.
- READ:
  - mem_addr = base+beat, mem_we=0. Each cycle shift mem_rdata into the assembly register, MSB cell first.
  - At beat=CELLS-1: register f_rdata, pulse f_rvalid the next cycle, return to IDLE.
- WRITE:
  - mem_addr = base+beat, mem_we=1, mem_wdata = l_wdata cell (CELLS-1-beat); beat 0 carries bits [WORD_LEN-1:WORD_LEN-CELL_W].
  - At beat=CELLS-1: pulse l_done the next cycle, return to IDLE.
- Latency: accept at edge E0; cell accesses in cycles 1..CELLS; f_rvalid/l_done high in cycle CELLS+1. That cycle is IDLE, so a new accept may coincide with the pulse. Throughput is one word per CELLS+1 cycles.
- Address arithmetic: base+beat is truncated to ADDR_W bits, so it wraps modulo MEM_SIZE. Unaligned bases are legal.
- f_flush:
  - In READ: return to IDLE next edge, no f_rvalid, f_rdata unchanged.
  - In IDLE: f_ready is forced 0.
  - In WRITE: ignored.
- Requester inputs are sampled only at accept. Later changes to f_addr, l_addr, or l_wdata do not affect an in-flight transaction.
- mem_we is 0 in IDLE and READ.
- Reset asserted mid-WRITE: abort immediately, no l_done. The cells already written keep their values; completing the word is the loader's responsibility.

Test Plan:
- Loader writes 0x3304 to addr 8 -> mem writes cells 8..11 = 3,3,0,4 over 4 cycles; l_done pulses in cycle 5. Fetch from 8 then returns f_rdata=0x3304 with f_rvalid 5 cycles after accept.
- Both valid after reset, continuously -> grants alternate L,F,L,F. Each pulse is one cycle; f_ready and l_ready are never both high.
- Write 0xA5C3 at addr 30 -> cells 30,31,0,1 = A,5,C,3 (wrap); fetch at 30 returns 0xA5C3.
- Fetch accepted, f_flush asserted in beat 2 -> no f_rvalid, state IDLE next cycle, f_rdata holds its prior value. A following loader request is accepted the cycle after.
- rst dropped mid-WRITE after beat 1 -> outputs 0 asynchronously; cells base, base+1 updated, cells base+2, base+3 untouched; no l_done.
- Back-to-back fetches with f_valid held -> accepts every 5 cycles, each f_rvalid coincides with the next f_ready.

Source files
------------

// File: rtl/imem_port_sequencer_if.sv
// imem_port_sequencer_if: fetch, loader and memory-cell signals of the instruction memory port sequencer
interface imem_port_sequencer_if #(
  parameter int CELL_W   = 4,
  parameter int CELLS    = 4,
  parameter int MEM_SIZE = 32,
  parameter int ADDR_W   = $clog2(MEM_SIZE)
);
  localparam int WORD_LEN = CELL_W * CELLS;
  logic                f_valid;
  logic [ADDR_W-1:0]   f_addr;
  logic                f_ready;
  logic                f_flush;
  logic                f_rvalid;
  logic [WORD_LEN-1:0] f_rdata;
  logic                l_valid;
  logic [ADDR_W-1:0]   l_addr;
  logic [WORD_LEN-1:0] l_wdata;
  logic                l_ready;
  logic                l_done;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [CELL_W-1:0]   mem_wdata;
  logic [CELL_W-1:0]   mem_rdata;
  modport master (
    output f_valid, f_addr, f_flush, l_valid, l_addr, l_wdata, mem_rdata,
    input  f_ready, f_rvalid, f_rdata, l_ready, l_done, mem_addr, mem_we, mem_wdata
  );
  modport slave (
    input  f_valid, f_addr, f_flush, l_valid, l_addr, l_wdata, mem_rdata,
    output f_ready, f_rvalid, f_rdata, l_ready, l_done, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_port_sequencer.sv
// imem_port_sequencer: shares one cell-wide instruction memory port between fetch reads and loader writes
module imem_port_sequencer #(
  parameter int CELL_W   = 4,
  parameter int CELLS    = 4,
  parameter int MEM_SIZE = 32,
  parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
  input logic clk,
  input logic rst,
  imem_port_sequencer_if.slave bus
);
  localparam int WORD_LEN = CELL_W * CELLS;
  localparam int BW = CELLS > 1 ? $clog2(CELLS) : 1;
  localparam logic [BW-1:0] LAST = BW'(CELLS - 1);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2;
  localparam logic FETCH = 1'b0, LOAD = 1'b1;
  logic [1:0]          state;
  logic [BW-1:0]       beat;
  logic                last_grant;
  logic [ADDR_W-1:0]   base;
  logic [WORD_LEN-1:0] wsr, shreg, shreg_d, rdata;
  logic                rvalid, done, idle, f_req, f_rdy, l_rdy, fin;
  always_comb begin
    idle    = rst && state == IDLE;
    f_req   = bus.f_valid && !bus.f_flush;
    f_rdy   = idle && f_req && (!bus.l_valid || last_grant == LOAD);
    l_rdy   = idle && bus.l_valid && (!f_req || last_grant == FETCH);
    fin     = beat == LAST;
    shreg_d = {shreg[WORD_LEN-CELL_W-1:0], bus.mem_rdata};
  end
  assign bus.f_ready   = f_rdy;
  assign bus.l_ready   = l_rdy;
  assign bus.f_rvalid  = rvalid;
  assign bus.f_rdata   = rdata;
  assign bus.l_done    = done;
  assign bus.mem_addr  = state == IDLE ? '0 : base + ADDR_W'(beat);
  assign bus.mem_we    = state == WRITE;
  assign bus.mem_wdata = state == WRITE ? wsr[WORD_LEN-1 -: CELL_W] : '0;
  // wsr shifts left each write beat so the next cell is always the top one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat       <= '0;
      last_grant <= FETCH;
      base       <= '0;
      wsr        <= '0;
      shreg      <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      done       <= 1'b0;
    end else begin
      rvalid <= state == READ && fin && !bus.f_flush;
      done   <= state == WRITE && fin;
      if (f_rdy || l_rdy) begin
        state      <= f_rdy ? READ : WRITE;
        base       <= f_rdy ? bus.f_addr : bus.l_addr;
        wsr        <= bus.l_wdata;
        last_grant <= l_rdy;
        beat       <= '0;
      end else if (state == READ) begin
        shreg <= shreg_d;
        beat  <= fin || bus.f_flush ? '0 : beat + BW'(1);
        if (fin && !bus.f_flush) rdata <= shreg_d;
        if (fin || bus.f_flush) state <= IDLE;
      end else if (state == WRITE) begin
        wsr  <= wsr << CELL_W;
        beat <= fin ? '0 : beat + BW'(1);
        if (fin) state <= IDLE;
      end else if (state != IDLE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_imem_port_sequencer.sv
// tb_imem_port_sequencer: directed stimulus with a queue scoreboard for f_rvalid / l_done pulses
module tb_imem_port_sequencer;
  localparam int CELL_W = 4, CELLS = 4, MEM_SIZE = 32;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  imem_port_sequencer_if #(.CELL_W(CELL_W), .CELLS(CELLS), .MEM_SIZE(MEM_SIZE)) b();
  imem_port_sequencer #(.CELL_W(CELL_W), .CELLS(CELLS), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst), .bus(b));
  logic [3:0] mem [MEM_SIZE];
  always @(posedge clk) if (b.mem_we) mem[b.mem_addr] <= b.mem_wdata;
  assign b.mem_rdata = mem[b.mem_addr];
  typedef struct {int cyc; logic [15:0] d;} rexp_t;
  rexp_t fq[$];
  int lq[$];
  int cyc = 0, checks = 0, failures = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    rexp_t e;
    int c;
    chk("ready_excl", 32'(b.f_ready & b.l_ready), 32'd0);
    if (b.f_rvalid) begin
      if (fq.size() == 0) begin
        checks++; failures++;
        $display("FAIL f_rvalid_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = fq.pop_front();
        chk("f_rvalid_cycle", 32'(cyc), 32'(e.cyc));
        chk("f_rdata", 32'(b.f_rdata), 32'(e.d));
      end
    end
    if (b.l_done) begin
      if (lq.size() == 0) begin
        checks++; failures++;
        $display("FAIL l_done_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        c = lq.pop_front();
        chk("l_done_cycle", 32'(cyc), 32'(c));
      end
    end
  end
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!(b.f_ready || b.l_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++; failures++;
      $display("FAIL ready_timeout: got no ready expected one within 20 cycles");
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    b.l_addr = a; b.l_wdata = d; b.l_valid = 1'b1;
    wait_ready();
    chk("wr_grant", 32'(b.l_ready), 32'd1);
    lq.push_back(cyc + 5);
    @(posedge clk); #1;
    b.l_valid = 1'b0; b.l_addr = 5'($urandom); b.l_wdata = 16'($urandom);
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [4:0] a, input logic [15:0] d);
    b.f_addr = a; b.f_valid = 1'b1;
    wait_ready();
    chk("rd_grant", 32'(b.f_ready), 32'd1);
    fq.push_back('{cyc + 5, d});
    @(posedge clk); #1;
    b.f_valid = 1'b0; b.f_addr = 5'($urandom);
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic chk_cells(input logic [4:0] a, input logic [15:0] d);
    for (int i = 0; i < 4; i++) chk("cell", 32'(mem[5'(a + 5'(i))]), 32'(d[15-4*i -: 4]));
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100us");
    $fatal(1, "timeout");
  end
  initial begin
    int prev = 0;
    b.f_valid = 1'b1; b.f_addr = '0; b.f_flush = 1'b0;
    b.l_valid = 1'b1; b.l_addr = '0; b.l_wdata = '0;
    #12;
    chk("rst_f_ready", 32'(b.f_ready), 32'd0);
    chk("rst_l_ready", 32'(b.l_ready), 32'd0);
    chk("rst_f_rvalid", 32'(b.f_rvalid), 32'd0);
    chk("rst_l_done", 32'(b.l_done), 32'd0);
    chk("rst_mem_we", 32'(b.mem_we), 32'd0);
    chk("rst_f_rdata", 32'(b.f_rdata), 32'd0);
    chk("rst_mem_addr", 32'(b.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(b.mem_wdata), 32'd0);
    b.f_valid = 1'b0; b.l_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    // both requesters held: loader first, then alternate
    b.l_addr = 5'd4; b.l_wdata = 16'h1234; b.f_addr = 5'd4;
    b.l_valid = 1'b1; b.f_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ready();
      chk("tie_grant", 32'({b.l_ready, b.f_ready}), (g % 2 == 0) ? 32'd2 : 32'd1);
      if (b.l_ready) lq.push_back(cyc + 5);
      else fq.push_back('{cyc + 5, 16'h1234});
      @(posedge clk);
    end
    #1 b.l_valid = 1'b0; b.f_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    wr(5'd8, 16'h3304);
    chk_cells(5'd8, 16'h3304);
    rd(5'd8, 16'h3304);
    wr(5'd30, 16'hA5C3);
    chk_cells(5'd30, 16'hA5C3);
    rd(5'd30, 16'hA5C3);
    // flush during beat 2 of a fetch
    b.f_addr = 5'd8; b.f_valid = 1'b1;
    wait_ready();
    chk("fl_grant", 32'(b.f_ready), 32'd1);
    @(posedge clk); #1 b.f_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    b.f_flush = 1'b1; b.f_valid = 1'b1;
    b.l_valid = 1'b1; b.l_addr = 5'd12; b.l_wdata = 16'hBEEF;
    @(negedge clk);
    chk("flush_busy", 32'({b.l_ready, b.f_ready}), 32'd0);
    @(negedge clk);
    chk("flush_l_ready", 32'(b.l_ready), 32'd1);
    chk("flush_f_ready", 32'(b.f_ready), 32'd0);
    chk("flush_rdata_hold", 32'(b.f_rdata), 32'hA5C3);
    lq.push_back(cyc + 5);
    @(posedge clk); #1;
    b.f_flush = 1'b0; b.f_valid = 1'b0; b.l_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_cells(5'd12, 16'hBEEF);
    // reset in the middle of a write
    wr(5'd20, 16'h00FF);
    b.l_addr = 5'd20; b.l_wdata = 16'h9876; b.l_valid = 1'b1;
    wait_ready();
    chk("mid_grant", 32'(b.l_ready), 32'd1);
    @(posedge clk); #1 b.l_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("mid_mem_we", 32'(b.mem_we), 32'd0);
    chk("mid_mem_addr", 32'(b.mem_addr), 32'd0);
    chk("mid_mem_wdata", 32'(b.mem_wdata), 32'd0);
    chk("mid_f_rdata", 32'(b.f_rdata), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_cells(5'd20, 16'h98FF);
    // back-to-back fetches
    b.f_addr = 5'd8; b.f_valid = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_ready();
      chk("b2b_grant", 32'(b.f_ready), 32'd1);
      if (g > 0) begin
        chk("b2b_spacing", 32'(cyc - prev), 32'd5);
        chk("b2b_rvalid_with_ready", 32'(b.f_rvalid), 32'd1);
      end
      prev = cyc;
      fq.push_back('{cyc + 5, 16'h3304});
      @(posedge clk);
    end
    #1 b.f_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pending_f", 32'(fq.size()), 32'd0);
    chk("pending_l", 32'(lq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
